pwm_duty_generator: RTL and testbench
=====================================

Name: pwm_duty_generator

Overview:
Consumes the 16-bit duty word driven by the processor's PIO output port and produces a single-bit PWM waveform.
- Period and prescale come from sibling PIO ports.
- Duty, period and prescale are double-buffered: new values take effect only at a period boundary, so software writes never cause glitches.
- Sits between the Avalon PIO outputs and the FPGA output pin / wave-shaping logic.

Parameters:
WIDTH, 16, width of duty, period and main counter.
PRESCALE_WIDTH, 8, width of prescale value and prescale counter.

Ports:
clk  input  1  system clock; all logic rising-edge.
reset  input  1  asynchronous active-high reset.
enable  input  1  level; 1 = run the generator.
duty_in  input  WIDTH  requested high-time in counter ticks (from PIO out_port).
period_in  input  WIDTH  requested period minus one, in counter ticks.
prescale_in  input  PRESCALE_WIDTH  clk cycles per counter tick, minus one.
pwm_out  output  1  registered PWM waveform.
period_tick  output  1  one-clk pulse on the cycle the main counter wraps.
busy  output  1  1 when state is not IDLE.
duty_active  output  WIDTH  duty value currently in use (shadow register).

Behaviour:
- Reset (async, active-high):
  - state = IDLE; counters, shadows and duty_active = 0.
  - pwm_out = 0, period_tick = 0, busy = 0.
  - Reset mid-operation clears everything immediately; there is no partial-period completion.
- Counters:
  - ps_cnt counts 0..prescale_sh. The tick is asserted on the cycle ps_cnt == prescale_sh; ps_cnt then returns to 0.
  - prescale_sh = 0 gives a tick every clk.
  - On each tick, cnt increments. When cnt == period_sh at a tick, cnt wraps to 0.
  - Period length = (period_sh+1)*(prescale_sh+1) clk cycles.
- Shadow load:
  - duty_sh, period_sh and prescale_sh load from the inputs on IDLE->RUN and on every wrap.
  - A wrap asserts period_tick for exactly one clk, in the same cycle the shadows are loaded.
  - Input changes mid-period have no effect until the next wrap.
- Output:
  - pwm_out <= (state != IDLE) && (cnt < duty_sh), registered, so it follows cnt with one clk of latency.
  - duty_sh = 0 gives a constant 0.
  - duty_sh > period_sh gives a constant 1 (100%).
  - Comparison is unsigned, full WIDTH.
  - period_sh = 0: cnt stays 0; pwm_out = 1 iff duty_sh != 0; period_tick fires every tick.
- State machine:
  - IDLE:
    - cnt and ps_cnt held at 0; pwm_out 0.
    - enable = 1 -> load shadows, go to RUN.
    - Counting starts the next cycle, with cnt = 0 already valid on the load cycle.
  - RUN:
    - Normal counting.
    - enable = 0 -> STOP_PENDING.
  - STOP_PENDING:
    - Counting and output continue unchanged until the next wrap.
    - At the wrap: go to IDLE, pwm_out becomes 0 one clk later, and no shadow load occurs.
    - period_tick still pulses at this wrap.
    - enable = 1 before the wrap -> back to RUN with no restart and no phase change.
  - Simultaneous events: enable falling on the same cycle as a wrap -> the wrap is processed as in RUN (shadows load), then STOP_PENDING.
- busy = (state != IDLE), registered with the state.
- duty_active = duty_sh.

Test Plan:
1. Reset, then prescale = 0, period = 9, duty = 3, enable = 1 -> pwm_out high 3 clk, low 7 clk, repeating; period_tick every 10 clk, aligned with the start of the high phase (1 clk before pwm_out rises).
2. Running as in 1, write duty = 7 at cycle 4 of a period -> the current period stays 3/10; the next period is 7/10; duty_active changes exactly on the period_tick cycle.
3. prescale = 1, period = 3, duty = 2 -> pwm_out high 4 clk, low 4 clk, period 8 clk.
4. duty = 0 -> pwm_out constantly 0; duty = 10 with period = 9 -> pwm_out constantly 1; period = 0 with duty = 1 -> pwm_out constantly 1 and period_tick every clk.
5. Drop enable at cycle 2 of a period (period = 9, duty = 3) -> the period completes, pwm_out stays 0 afterward, busy falls at the wrap. Repeat, re-asserting enable at cycle 6 -> no gap and no phase shift.
6. Assert reset while pwm_out = 1 mid-period -> pwm_out, busy and duty_active go to 0 asynchronously. After reset is released with enable = 1 -> a fresh period starts from cnt = 0.

Source files
------------

// File: rtl/pwm_duty_generator_if.sv
// Control/status bundle between the PIO output ports and the PWM generator.
// The master drives duty/period/prescale/enable; the slave returns the waveform and status.
interface pwm_duty_generator_if #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
);
  logic                      enable;
  logic [WIDTH-1:0]          duty_in;
  logic [WIDTH-1:0]          period_in;
  logic [PRESCALE_WIDTH-1:0] prescale_in;
  logic                      pwm_out;
  logic                      period_tick;
  logic                      busy;
  logic [WIDTH-1:0]          duty_active;

  modport master (
    output enable, duty_in, period_in, prescale_in,
    input  pwm_out, period_tick, busy, duty_active
  );

  modport slave (
    input  enable, duty_in, period_in, prescale_in,
    output pwm_out, period_tick, busy, duty_active
  );
endinterface

// File: rtl/pwm_duty_generator.sv
// Double-buffered PWM generator: duty, period and prescale are sampled into shadow
// registers only at start-up and at each period wrap, so mid-period writes never glitch.
module pwm_duty_generator #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  pwm_duty_generator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RUN          = 2'd1,
    STOP_PENDING = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] ps_cnt_q, ps_cnt_d;
  logic [PRESCALE_WIDTH-1:0] prescale_sh_q, prescale_sh_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          duty_sh_q, duty_sh_d;
  logic [WIDTH-1:0]          period_sh_q, period_sh_d;
  logic                      pwm_q, pwm_d;
  logic                      tick_q, tick_d;
  logic                      ps_tick;
  logic                      wrap;
  logic                      stop_now;

  // NOTE: every state register, shadows included, is cleared by the async reset so a
  // reset mid-period abandons the period outright instead of finishing it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ps_cnt_q      <= '0;
      prescale_sh_q <= '0;
      cnt_q         <= '0;
      duty_sh_q     <= '0;
      period_sh_q   <= '0;
      pwm_q         <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ps_cnt_q      <= ps_cnt_d;
      prescale_sh_q <= prescale_sh_d;
      cnt_q         <= cnt_d;
      duty_sh_q     <= duty_sh_d;
      period_sh_q   <= period_sh_d;
      pwm_q         <= pwm_d;
      tick_q        <= tick_d;
    end
  end

  // NOTE: every signal gets a default at the top so no path through the case infers a latch.
  always_comb begin
    ps_tick       = (ps_cnt_q == prescale_sh_q);
    wrap          = ps_tick && (cnt_q == period_sh_q);
    stop_now      = (state_q == STOP_PENDING) && !bus.enable && wrap;
    state_d       = state_q;
    ps_cnt_d      = ps_cnt_q;
    cnt_d         = cnt_q;
    prescale_sh_d = prescale_sh_q;
    duty_sh_d     = duty_sh_q;
    period_sh_d   = period_sh_q;
    tick_d        = 1'b0;
    pwm_d         = (state_q != IDLE) && (cnt_q < duty_sh_q);

    unique case (state_q)
      IDLE: begin
        ps_cnt_d = '0;
        cnt_d    = '0;
        if (bus.enable) begin
          duty_sh_d     = bus.duty_in;
          period_sh_d   = bus.period_in;
          prescale_sh_d = bus.prescale_in;
          state_d       = RUN;
        end
      end
      RUN, STOP_PENDING: begin
        ps_cnt_d = ps_tick ? '0 : ps_cnt_q + 1'b1;
        if (ps_tick) begin
          cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        tick_d = wrap;
        // The final wrap of a pending stop pulses period_tick but keeps the old shadows.
        if (wrap && !stop_now) begin
          duty_sh_d     = bus.duty_in;
          period_sh_d   = bus.period_in;
          prescale_sh_d = bus.prescale_in;
        end
        if (bus.enable)    state_d = RUN;
        else if (stop_now) state_d = IDLE;
        else               state_d = STOP_PENDING;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_tick = tick_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.duty_active = duty_sh_q;

endmodule

// File: tb/tb_pwm_duty_generator.sv
// Directed bench for pwm_duty_generator: a table of steady-state configurations plus
// hand-written sequences for start-up, mid-period writes, stop/restart and async reset.
module tb_pwm_duty_generator;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pwm_duty_generator_if #(.WIDTH(16), .PRESCALE_WIDTH(8)) bus ();

  pwm_duty_generator #(.WIDTH(16), .PRESCALE_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] duty;
    logic [15:0] period;
    logic [7:0]  prescale;
    int          high;   // pwm_out high clk cycles per period
    int          plen;   // period length in clk cycles
  } vec_t;

  vec_t        vecs [8];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [63:0] pwm_log, tick_log, busy_log;
  logic [15:0] da_log [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Samples outputs on the falling edge for n cycles; optionally changes inputs after sampling.
  task automatic capture(input int n, input int drop_at, input int raise_at,
                         input int duty_at, input logic [15:0] duty_new);
    pwm_log  = '0;
    tick_log = '0;
    busy_log = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      pwm_log[i-1]  = bus.pwm_out;
      tick_log[i-1] = bus.period_tick;
      busy_log[i-1] = bus.busy;
      da_log[i-1]   = bus.duty_active;
      if (i == drop_at)  bus.enable  = 1'b0;
      if (i == raise_at) bus.enable  = 1'b1;
      if (i == duty_at)  bus.duty_in = duty_new;
    end
  endtask

  task automatic wait_tick(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.period_tick) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_tick_seen"}, {63'd0, found}, 64'd1);
  endtask

  // Enable was just raised from IDLE with duty=3, period=9, prescale=0.
  task automatic start_seq(input string name);
    capture(11, 0, 0, 0, 16'd0);
    check({name, "_pwm"},  pwm_log,  64'h00E);
    check({name, "_tick"}, tick_log, 64'h400);
    check({name, "_busy"}, busy_log, 64'h7FF);
    check({name, "_duty_active"}, {48'd0, da_log[0]}, 64'd3);
  endtask

  initial begin
    logic [63:0] exp_p, exp_t;
    int          k;

    vecs[0] = '{duty: 16'd3,  period: 16'd9, prescale: 8'd0, high: 3,  plen: 10};
    vecs[1] = '{duty: 16'd2,  period: 16'd3, prescale: 8'd1, high: 4,  plen: 8};
    vecs[2] = '{duty: 16'd0,  period: 16'd9, prescale: 8'd0, high: 0,  plen: 10};
    vecs[3] = '{duty: 16'd10, period: 16'd9, prescale: 8'd0, high: 10, plen: 10};
    vecs[4] = '{duty: 16'd1,  period: 16'd0, prescale: 8'd0, high: 1,  plen: 1};
    vecs[5] = '{duty: 16'd5,  period: 16'd4, prescale: 8'd2, high: 15, plen: 15};
    vecs[6] = '{duty: 16'd1,  period: 16'd1, prescale: 8'd3, high: 4,  plen: 8};
    vecs[7] = '{duty: 16'd0,  period: 16'd0, prescale: 8'd0, high: 0,  plen: 1};

    bus.enable      = 1'b0;
    bus.duty_in     = 16'd0;
    bus.period_in   = 16'd0;
    bus.prescale_in = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pwm",         {63'd0, bus.pwm_out},     64'd0);
    check("rst_tick",        {63'd0, bus.period_tick}, 64'd0);
    check("rst_busy",        {63'd0, bus.busy},        64'd0);
    check("rst_duty_active", {48'd0, bus.duty_active}, 64'd0);

    // Basic 3/10 waveform from a cold start
    bus.duty_in   = 16'd3;
    bus.period_in = 16'd9;
    bus.enable    = 1'b1;
    reset         = 1'b0;
    start_seq("start");

    // duty=7 written at cycle 4: current period stays 3/10, next is 7/10
    capture(20, 0, 0, 4, 16'd7);
    check("midwrite_pwm",  pwm_log,  64'h1FC07);
    check("midwrite_tick", tick_log, 64'h80200);
    check("midwrite_da_before", {48'd0, da_log[8]}, 64'd3);
    check("midwrite_da_at_tick", {48'd0, da_log[9]}, 64'd7);

    // Steady-state configurations
    for (int v = 0; v < 8; v++) begin
      bus.duty_in     = vecs[v].duty;
      bus.period_in   = vecs[v].period;
      bus.prescale_in = vecs[v].prescale;
      wait_tick($sformatf("vec%0d", v));
      capture(2 * vecs[v].plen, 0, 0, 0, 16'd0);
      exp_p = '0;
      exp_t = '0;
      for (int i = 1; i <= 2 * vecs[v].plen; i++) begin
        k = (i - 1) % vecs[v].plen + 1;
        if (k <= vecs[v].high) exp_p[i-1] = 1'b1;
        if (k == vecs[v].plen) exp_t[i-1] = 1'b1;
      end
      check($sformatf("vec%0d_pwm", v),  pwm_log,  exp_p);
      check($sformatf("vec%0d_tick", v), tick_log, exp_t);
      check($sformatf("vec%0d_busy", v), busy_log, (64'd1 << (2 * vecs[v].plen)) - 64'd1);
      check($sformatf("vec%0d_duty_active", v), {48'd0, da_log[0]}, {48'd0, vecs[v].duty});
    end

    // Stop at cycle 2: the period completes, then the generator idles
    bus.duty_in     = 16'd3;
    bus.period_in   = 16'd9;
    bus.prescale_in = 8'd0;
    wait_tick("stop");
    capture(20, 2, 0, 0, 16'd0);
    check("stop_pwm",  pwm_log,  64'h7);
    check("stop_tick", tick_log, 64'h200);
    check("stop_busy", busy_log, 64'h1FF);
    check("stop_duty_active", {48'd0, da_log[19]}, 64'd3);

    // Restart, then drop at cycle 2 and re-raise at cycle 6: no gap, no phase shift
    bus.enable = 1'b1;
    start_seq("restart");
    capture(20, 2, 6, 0, 16'd0);
    check("bounce_pwm",  pwm_log,  64'h1C07);
    check("bounce_tick", tick_log, 64'h80200);
    check("bounce_busy", busy_log, 64'hFFFFF);

    // Async reset while pwm_out is high
    capture(2, 0, 0, 0, 16'd0);
    check("pre_reset_pwm", {63'd0, pwm_log[1]}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pwm",         {63'd0, bus.pwm_out},     64'd0);
    check("async_rst_busy",        {63'd0, bus.busy},        64'd0);
    check("async_rst_duty_active", {48'd0, bus.duty_active}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start_seq("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
